float_to_fixed_converter: RTL

- Downstream stage of the polynomial estimator chain. Converts the estimator's IEEE-754 single-precision output stream to signed fixed point for the codec/DAC path.
- Rounds to nearest, ties away from zero, and saturates to the output range.
- Counts saturation events for software readback.
- AXI-stream-style valid/ready on both sides, 3-stage pipeline.

---
 rtl/float_to_fixed_converter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/float_to_fixed_converter.sv
// fp32 -> signed fixed-point converter: round to nearest (ties away from zero),
// saturate to the output range, count clamped samples. 3-stage valid/ready pipeline.
module float_to_fixed_converter #(
  parameter int G_OUT_DWIDTH = 24,
  parameter int G_FRAC_BITS  = 23
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    sat_count_clear,
  input  logic [31:0]             din,
  input  logic                    din_valid,
  output logic                    din_ready,
  output logic [G_OUT_DWIDTH-1:0] dout,
  output logic                    dout_valid,
  input  logic                    dout_ready,
  output logic [15:0]             sat_count
);

  localparam int W  = G_OUT_DWIDTH;
  localparam int WW = W + 25;  // wide enough for any in-range shift or rounded right-shift

  localparam logic [W:0] C_MAX_POS = {2'b00, {(W-1){1'b1}}};
  localparam logic [W:0] C_MAX_NEG = {2'b01, {(W-1){1'b0}}};

  typedef struct packed {
    logic               sign;
    logic               zero;  // zero, denormal or NaN
    logic               inf;
    logic [23:0]        mant;
    logic signed [10:0] k;
  } s1_t;

  typedef struct packed {
    logic       sign;
    logic       ovf;
    logic [W:0] mag;
  } s2_t;

  logic [2:0]   r_vld_pipe;
  s1_t          r_s1, w_s1;
  s2_t          r_s2, w_s2;
  logic [W-1:0] r_dout, w_dout;
  logic [15:0]  r_sat_cnt;
  logic         w_sat;
  logic         w_adv;
  logic [WW-1:0] w_wide;
  logic [10:0]  w_r;
  logic [24:0]  w_tmp;
  logic [24:0]  w_rnd;

  assign w_adv      = enable & (~r_vld_pipe[2] | dout_ready);
  assign din_ready  = w_adv;
  assign dout       = r_dout;
  assign dout_valid = r_vld_pipe[2];
  assign sat_count  = r_sat_cnt;

  // Stage 1: decode
  always_comb begin
    w_s1      = '0;
    w_s1.sign = din[31];
    w_s1.zero = (din[30:23] == 8'd0) | ((din[30:23] == 8'hFF) & (din[22:0] != 23'd0));
    w_s1.inf  = (din[30:23] == 8'hFF) & (din[22:0] == 23'd0);
    w_s1.mant = {1'b1, din[22:0]};
    w_s1.k    = $signed({3'b000, din[30:23]}) + 11'(G_FRAC_BITS) - 11'sd150;
  end

  // Stage 2: scale and round. Any bit at or above position W means the
  // magnitude already exceeds every representable value.
  always_comb begin
    w_wide    = '0;
    w_r       = '0;
    w_tmp     = '0;
    w_rnd     = '0;
    w_s2      = '0;
    w_s2.sign = r_s1.sign;
    if (r_s1.zero) begin
      w_s2.ovf = 1'b0;
    end else if (r_s1.inf) begin
      w_s2.ovf = 1'b1;
    end else if (!r_s1.k[10]) begin
      if (r_s1.k >= 11'(W)) w_s2.ovf = 1'b1;
      else                  w_wide   = WW'(r_s1.mant) << r_s1.k[5:0];
    end else begin
      // shifting {m,0} leaves the round bit m[r-1] in bit 0; r >= 25 yields 0
      w_r    = -r_s1.k;
      w_tmp  = {r_s1.mant, 1'b0} >> w_r;
      w_rnd  = {1'b0, w_tmp[24:1]} + {24'd0, w_tmp[0]};
      w_wide = WW'(w_rnd);
    end
    w_s2.ovf = w_s2.ovf | (|w_wide[WW-1:W]);
    w_s2.mag = w_wide[W:0];
  end

  // Stage 3: apply sign and saturate on the post-round magnitude
  always_comb begin
    w_sat  = 1'b0;
    w_dout = r_s2.sign ? (~r_s2.mag[W-1:0] + W'(1)) : r_s2.mag[W-1:0];
    if (!r_s2.sign) begin
      if (r_s2.ovf || (r_s2.mag > C_MAX_POS)) begin
        w_sat  = 1'b1;
        w_dout = {1'b0, {(W-1){1'b1}}};
      end
    end else if (r_s2.ovf || (r_s2.mag > C_MAX_NEG)) begin
      w_sat  = 1'b1;
      w_dout = {1'b1, {(W-1){1'b0}}};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld_pipe <= '0;
      r_s1       <= '0;
      r_s2       <= '0;
      r_dout     <= '0;
      r_sat_cnt  <= '0;
    end else if (enable) begin
      if (w_adv) begin
        r_vld_pipe <= {r_vld_pipe[1:0], din_valid};
        r_s1       <= w_s1;
        r_s2       <= w_s2;
        if (r_vld_pipe[1]) r_dout <= w_dout;
      end
      if (sat_count_clear)
        r_sat_cnt <= '0;
      else if (w_adv && r_vld_pipe[1] && w_sat && (r_sat_cnt != 16'hFFFF))
        r_sat_cnt <= r_sat_cnt + 16'd1;
    end
  end

endmodule
